i2c_tx_fifo_read_ctrl: RTL and testbench
========================================

# i2c_tx_fifo_read_ctrl

Read-side sequencer for the I2C transmit FIFO. It runs in the FIFO read-clock domain and consumes the synchronized-pointer FIFO's `empty` flag and read data. It pops one byte at a time, hands each byte to the I2C byte shifter over a valid/ready handshake, and waits for the byte's ACK/NACK result. It counts bytes against a programmed transaction length and reports completion, NACK abort and FIFO starvation to the master control FSM.

## Interface
- `data_size`, default 8: FIFO word / I2C byte width.
- `count_size`, default 8: byte-counter width; maximum transaction length is 2^count_size-1.

Ports:
- `clock_i`  in  1: FIFO read-domain clock; all logic on the rising edge.
- `reset_i`  in  1: asynchronous, active-high reset.
- `enable_i`  in  1: block enable; gates acceptance of `start_i` only.
- `start_i`  in  1: one-cycle request to begin a transaction.
- `abort_i`  in  1: immediate return to IDLE from any state.
- `length_i`  in  count_size: bytes in the transaction, sampled with `start_i`.
- `fifo_empty_i`  in  1: FIFO empty flag (read domain).
- `fifo_data_i`  in  data_size: FIFO read data, valid one cycle after `fifo_read_en_o`.
- `fifo_read_en_o`  out  1: FIFO pop strobe.
- `tx_data_o`  out  data_size: byte offered to the shifter (registered).
- `tx_valid_o`  out  1: `tx_data_o` is valid.
- `tx_ready_i`  in  1: shifter accepts the byte.
- `tx_done_i`  in  1: one-cycle pulse; the shifter finished the byte and its ACK slot.
- `tx_nack_i`  in  1: NACK qualifier; valid only with `tx_done_i`.
- `busy_o`  out  1: high in every state except IDLE.
- `done_o`  out  1: one-cycle transaction-end pulse.
- `nack_o`  out  1: one-cycle pulse, coincident with `done_o`, when the transaction ended on a NACK.
- `underrun_o`  out  1: high while waiting for data on an empty FIFO.
- `bytes_left_o`  out  count_size: remaining byte count.

## Operation
- **Reset:** state = IDLE. Every output is 0, including `tx_data_o` and `bytes_left_o`.
- **IDLE**
  - `start_i && enable_i` with `length_i != 0`: load the counter with `length_i`, go to POP.
  - `start_i && enable_i` with `length_i == 0`: go to FINISH; `done_o` pulses and no FIFO access occurs.
  - `start_i` is ignored in any state other than IDLE.
- **POP**
  - `fifo_read_en_o = !fifo_empty_i`. This strobe is decoded from state and flag, and is high for exactly one cycle per byte.
  - Non-empty: go to LOAD.
  - Empty: stay in POP with `underrun_o = 1`.
- **LOAD:** register `fifo_data_i` into `tx_data_o`, go to OFFER.
- **OFFER**
  - `tx_valid_o = 1`; `tx_data_o` is held stable.
  - On `tx_ready_i`, go to WAIT_DONE. `tx_valid_o` deasserts the following cycle.
- **WAIT_DONE**
  - `tx_done_i && tx_nack_i`: set the NACK flag and go to FINISH. The counter is unchanged, so the NACKed byte is still counted.
  - `tx_done_i && !tx_nack_i`: decrement the counter. Go to FINISH if the counter was 1, otherwise go to POP.
  - `tx_done_i` received outside WAIT_DONE is ignored.
- **FINISH:** `done_o = 1`, and `nack_o` equals the NACK flag. Clear the NACK flag and go to IDLE. `bytes_left_o` holds its value until the next accepted start.
- **abort_i**
  - Highest priority. From any state, the next state is IDLE, with no `done_o` and no `nack_o`.
  - A byte already popped in LOAD or OFFER is discarded; the FIFO is not rewound.
  - `tx_valid_o` drops the cycle after `abort_i` is sampled.
- **Simultaneous events**
  - `abort_i` with `tx_done_i`: abort wins, and there is no decrement.
  - `abort_i` with `start_i` in IDLE: stay in IDLE.
  - `fifo_empty_i` deasserting while in POP: the pop occurs that same cycle.
- **Width rules:** the counter is unsigned, `count_size` bits, and never decrements below 1 inside the FSM, so there is no wrap-around.

## Timing
- Start accepted at edge 0:
  - POP during cycle 1. `fifo_read_en_o` is high in cycle 1 if the FIFO is non-empty.
  - LOAD during cycle 2.
  - `tx_valid_o` and the data are high from cycle 3.
- Minimum per-byte period is 4 cycles: POP, LOAD, OFFER accepted immediately, and a `tx_done_i` pulse one cycle after acceptance.
- `done_o` pulses one cycle after the final `tx_done_i`. `busy_o` falls on the cycle after `done_o`.
- `length_i == 0`: `done_o` pulses in cycle 1.
- Empty-FIFO stall: each stalled cycle adds 1 to the latency. `underrun_o` is high for exactly those cycles.

## Test plan
- **Basic transfer:** FIFO holds 0xA5, 0x3C; `length_i=2`; start; `tx_ready_i` tied high; `tx_done_i` 1 cycle after accept with ACK.
  - Exactly 2 pops and 2 offers, in order.
  - `done_o` pulses once with `nack_o=0`, and `bytes_left_o=0`.
- **NACK on byte 2 of 3:**
  - `done_o` and `nack_o` pulse together.
  - Only 2 pops occur.
  - `bytes_left_o=2`, and no third `tx_valid_o`.
- **Underrun:** `length_i=1` with an empty FIFO for 5 cycles, then write 0x7E.
  - `underrun_o` is high for 5 cycles, then a single pop occurs.
  - 0x7E is offered and `done_o` pulses after the ACK.
- **Backpressure and zero length:**
  - `tx_ready_i` low for 4 cycles: `tx_valid_o` and `tx_data_o` are held stable for all 4.
  - `length_i=0`: `done_o` in cycle 1 with no `fifo_read_en_o`.
- **Abort:**
  - `abort_i` in OFFER, and separately together with `tx_done_i`: IDLE next cycle, no `done_o`, no decrement.
  - A `start_i` during `busy_o` is ignored.
- **Mid-transfer reset:** assert `reset_i` in WAIT_DONE.
  - All outputs go to 0 asynchronously, before the next clock edge.
  - After release, a new `start_i` runs normally.

Source files
------------

// File: rtl/i2c_tx_fifo_read_ctrl.sv
// I2C transmit FIFO read-side sequencer.
// Pops bytes, offers them to the shifter, tracks ACK/NACK and byte count.
module i2c_tx_fifo_read_ctrl #(
  parameter int data_size  = 8,
  parameter int count_size = 8
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  enable_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [count_size-1:0] length_i,
  input  logic                  fifo_empty_i,
  input  logic [data_size-1:0]  fifo_data_i,
  output logic                  fifo_read_en_o,
  output logic [data_size-1:0]  tx_data_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  input  logic                  tx_done_i,
  input  logic                  tx_nack_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  nack_o,
  output logic                  underrun_o,
  output logic [count_size-1:0] bytes_left_o
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] POP       = 3'd1;
  localparam logic [2:0] LOAD      = 3'd2;
  localparam logic [2:0] OFFER     = 3'd3;
  localparam logic [2:0] WAIT_DONE = 3'd4;
  localparam logic [2:0] FINISH    = 3'd5;

  localparam logic [count_size-1:0] count_zero = '0;
  localparam logic [count_size-1:0] count_one  =
    {{(count_size-1){1'b0}}, 1'b1};

  logic [2:0]            state;
  logic [2:0]            state_nxt;
  logic [count_size-1:0] count;
  logic                  nack_flag;
  logic                  start_ok;
  logic                  byte_ack;
  logic                  byte_nack;

  assign start_ok  = start_i && enable_i && !abort_i;
  assign byte_ack  = (state == WAIT_DONE) && tx_done_i && !tx_nack_i;
  assign byte_nack = (state == WAIT_DONE) && tx_done_i && tx_nack_i;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_ok) begin
          state_nxt = (length_i == count_zero) ? FINISH : POP;
        end
      end
      POP: begin
        if (!fifo_empty_i) state_nxt = LOAD;
      end
      LOAD: state_nxt = OFFER;
      OFFER: begin
        if (tx_ready_i) state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (byte_nack) begin
          state_nxt = FINISH;
        end else if (byte_ack) begin
          state_nxt = (count == count_one) ? FINISH : POP;
        end
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort_i) state_nxt = IDLE;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Counter is only decremented on an ACKed byte; abort suppresses it.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      count <= '0;
    end else if ((state == IDLE) && start_ok) begin
      count <= length_i;
    end else if (byte_ack && !abort_i) begin
      count <= count - count_one;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      nack_flag <= 1'b0;
    end else if (abort_i || (state == FINISH)) begin
      nack_flag <= 1'b0;
    end else if (byte_nack) begin
      nack_flag <= 1'b1;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      tx_data_o <= '0;
    end else if (state == LOAD) begin
      tx_data_o <= fifo_data_i;
    end
  end

  assign fifo_read_en_o = (state == POP) && !fifo_empty_i;
  assign underrun_o     = (state == POP) && fifo_empty_i;
  assign tx_valid_o     = (state == OFFER);
  assign busy_o         = (state != IDLE);
  assign done_o         = (state == FINISH) && !abort_i;
  assign nack_o         = done_o && nack_flag;
  assign bytes_left_o   = count;

endmodule

// File: tb/tb_i2c_tx_fifo_read_ctrl.sv
// Directed bench for i2c_tx_fifo_read_ctrl.
// Behavioural FIFO and shifter around the DUT.
module tb_i2c_tx_fifo_read_ctrl;

  logic       clock_i = 1'b0;
  logic       reset_i;
  logic       enable_i;
  logic       start_i;
  logic       abort_i;
  logic [7:0] length_i;
  logic       fifo_empty_i;
  logic [7:0] fifo_data_i;
  logic       fifo_read_en_o;
  logic [7:0] tx_data_o;
  logic       tx_valid_o;
  logic       tx_ready_i;
  logic       tx_done_i;
  logic       tx_nack_i;
  logic       busy_o;
  logic       done_o;
  logic       nack_o;
  logic       underrun_o;
  logic [7:0] bytes_left_o;

  i2c_tx_fifo_read_ctrl #(.data_size(8), .count_size(8)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i),
    .start_i(start_i), .abort_i(abort_i), .length_i(length_i),
    .fifo_empty_i(fifo_empty_i), .fifo_data_i(fifo_data_i),
    .fifo_read_en_o(fifo_read_en_o), .tx_data_o(tx_data_o),
    .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .tx_done_i(tx_done_i), .tx_nack_i(tx_nack_i),
    .busy_o(busy_o), .done_o(done_o), .nack_o(nack_o),
    .underrun_o(underrun_o), .bytes_left_o(bytes_left_o)
  );

  always #5 clock_i = ~clock_i;

  logic [7:0] mem [64];
  int wr = 0;
  int rd = 0;
  assign fifo_empty_i = (wr == rd);

  int tests = 0;
  int fails = 0;
  int pop_cnt, offer_cnt, done_cnt, nack_cnt, nd_cnt, under_cnt;
  int cyc, done_cyc, nack_idx;
  logic auto_done;
  logic [7:0] log_b [8];
  logic s_busy, s_done, s_nack, s_valid, s_pop, s_under, s_acc;
  logic [7:0] s_data;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr] = b;
    wr++;
  endtask

  task automatic clear();
    pop_cnt = 0; offer_cnt = 0; done_cnt = 0; nack_cnt = 0;
    nd_cnt = 0; under_cnt = 0; done_cyc = -1; nack_idx = 0;
    auto_done = 1'b1;
    rd = wr;
  endtask

  // Sample on the falling edge, update stimulus 1 after the rising edge.
  task automatic tick();
    #4;
    s_busy = busy_o; s_done = done_o; s_nack = nack_o;
    s_valid = tx_valid_o; s_data = tx_data_o;
    s_pop = fifo_read_en_o; s_under = underrun_o;
    s_acc = tx_valid_o && tx_ready_i;
    if (s_done) begin done_cnt++; done_cyc = cyc; end
    if (s_nack) nack_cnt++;
    if (s_nack && s_done) nd_cnt++;
    if (s_under) under_cnt++;
    @(posedge clock_i);
    #1;
    cyc++;
    tx_done_i = 1'b0;
    tx_nack_i = 1'b0;
    if (s_pop) begin
      fifo_data_i = mem[rd];
      rd++;
      pop_cnt++;
    end
    if (s_acc) begin
      log_b[offer_cnt] = s_data;
      offer_cnt++;
      if (auto_done) begin
        tx_done_i = 1'b1;
        tx_nack_i = (offer_cnt == nack_idx);
      end
    end
  endtask

  task automatic go(input int len);
    length_i = len[7:0];
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    cyc = 1;
  endtask

  task automatic run();
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      tick();
      if (!s_busy) begin ok = 1'b1; break; end
    end
    check("idle_timeout", ok, 1);
  endtask

  initial begin
    reset_i = 1'b1; enable_i = 1'b1; start_i = 1'b0; abort_i = 1'b0;
    length_i = '0; fifo_data_i = '0; tx_ready_i = 1'b1;
    tx_done_i = 1'b0; tx_nack_i = 1'b0; cyc = 0;
    clear();
    @(posedge clock_i);
    #1;
    check("rst_busy", busy_o, 0);
    check("rst_valid", tx_valid_o, 0);
    check("rst_data", tx_data_o, 0);
    check("rst_left", bytes_left_o, 0);
    check("rst_done", done_o | nack_o | underrun_o | fifo_read_en_o, 0);
    reset_i = 1'b0;
    @(posedge clock_i);
    #1;

    // basic two-byte transfer
    clear(); push(8'hA5); push(8'h3C);
    go(2); run();
    check("b_pops", pop_cnt, 2);
    check("b_offers", offer_cnt, 2);
    check("b_byte0", log_b[0], 8'hA5);
    check("b_byte1", log_b[1], 8'h3C);
    check("b_done", done_cnt, 1);
    check("b_nack", nack_cnt, 0);
    check("b_left", bytes_left_o, 0);
    check("b_done_cyc", done_cyc, 9);

    // NACK on byte 2 of 3
    clear(); push(8'h11); push(8'h22); push(8'h33);
    nack_idx = 2;
    go(3); run();
    check("n_pops", pop_cnt, 2);
    check("n_offers", offer_cnt, 2);
    check("n_done", done_cnt, 1);
    check("n_nack_with_done", nd_cnt, 1);
    check("n_left", bytes_left_o, 2);

    // underrun for 5 cycles
    clear();
    go(1);
    for (int i = 0; i < 5; i++) tick();
    push(8'h7E);
    run();
    check("u_under", under_cnt, 5);
    check("u_pops", pop_cnt, 1);
    check("u_byte", log_b[0], 8'h7E);
    check("u_done", done_cnt, 1);
    check("u_done_cyc", done_cyc, 10);

    // backpressure
    clear(); push(8'h5A);
    tx_ready_i = 1'b0;
    go(1); tick(); tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_valid", s_valid, 1);
      check("bp_data", s_data, 8'h5A);
    end
    tx_ready_i = 1'b1;
    run();
    check("bp_offers", offer_cnt, 1);
    check("bp_done", done_cnt, 1);

    // zero length
    clear();
    go(0); tick();
    check("z_done_c1", s_done, 1);
    check("z_pop_c1", s_pop, 0);
    run();
    check("z_pops", pop_cnt, 0);
    check("z_left", bytes_left_o, 0);

    // abort in OFFER
    clear(); push(8'h66);
    tx_ready_i = 1'b0;
    go(2); tick(); tick();
    abort_i = 1'b1; tick(); abort_i = 1'b0;
    check("ao_valid_before", s_valid, 1);
    tick();
    check("ao_busy", s_busy, 0);
    check("ao_valid", s_valid, 0);
    check("ao_done", done_cnt, 0);
    check("ao_left", bytes_left_o, 2);
    tx_ready_i = 1'b1;

    // abort together with tx_done
    clear(); push(8'h77); push(8'h88);
    go(2); tick(); tick(); tick();
    abort_i = 1'b1; tick(); abort_i = 1'b0;
    tick();
    check("ad_busy", s_busy, 0);
    check("ad_done", done_cnt, 0);
    check("ad_nack", nack_cnt, 0);
    check("ad_left", bytes_left_o, 2);
    check("ad_pops", pop_cnt, 1);

    // start while busy is ignored
    clear(); push(8'h99);
    tx_ready_i = 1'b0;
    go(1); tick(); tick();
    length_i = 8'd5; start_i = 1'b1; tick(); start_i = 1'b0;
    tx_ready_i = 1'b1;
    run();
    check("sb_pops", pop_cnt, 1);
    check("sb_done", done_cnt, 1);
    check("sb_left", bytes_left_o, 0);

    // reset in WAIT_DONE
    clear(); push(8'hAB); push(8'hCD);
    auto_done = 1'b0;
    go(2); tick(); tick(); tick();
    reset_i = 1'b1;
    #1;
    check("mr_busy", busy_o, 0);
    check("mr_valid", tx_valid_o, 0);
    check("mr_data", tx_data_o, 0);
    check("mr_left", bytes_left_o, 0);
    #2;
    reset_i = 1'b0;
    @(posedge clock_i);
    #1;
    clear(); push(8'h42);
    go(1); run();
    check("mr2_byte", log_b[0], 8'h42);
    check("mr2_done", done_cnt, 1);
    check("mr2_left", bytes_left_o, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
